// File: rtl/mul53_seq.sv
// mul53_seq - sequential 53x53-bit unsigned mantissa multiplier.
//
// Iterates over the multiplier MSB-first and accumulates partial products
// into a 106-bit product. It then spends one cycle on leading-one detection,
// so the normaliser receives both the raw product and the index of its top bit.
//
// Build option:
//   MUL53_RADIX256_EN  8 multiplier bits per cycle (7 MUL cycles).
//                      When it is not defined, 4 bits per cycle (14 MUL cycles).
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_ena       start request, sampled only in IDLE
//   i_a, i_b    53-bit unsigned operands (hidden bit included)
//   o_busy      high whenever the FSM is not in IDLE
//   o_rdy       one-cycle pulse, result outputs valid
//   o_result    106-bit product, held until the next NORM
//   o_shift     index of the highest set bit of o_result (0 if zero)
//   o_zero      product is zero
//   o_overflow  o_result[105]
//
// state | meaning
// IDLE  | waiting for i_ena; o_rdy pulses here after NORM
// MUL   | one multiplier digit per cycle, accumulate MSB-first
// NORM  | leading-one detect, register the outputs
module mul53_seq (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ena,
    input  logic [52:0]  i_a,
    input  logic [52:0]  i_b,
    output logic         o_busy,
    output logic         o_rdy,
    output logic [105:0] o_result,
    output logic [6:0]   o_shift,
    output logic         o_zero,
    output logic         o_overflow
);

`ifdef MUL53_RADIX256_EN
    localparam int         DW   = 8;
    localparam logic [3:0] LAST = 4'd6;
`else
    localparam int         DW   = 4;
    localparam logic [3:0] LAST = 4'd13;
`endif

    typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

    state_t         state_q, state_d;
    logic [52:0]    r_a;
    logic [55:0]    r_b;
    logic [105:0]   r_acc;
    logic [3:0]     r_cnt;
    logic [52+DW:0] pp;
    logic [105:0]   acc_next;
    logic [6:0]     lead;

    // Partial product of the multiplicand and the current top digit.
    // The final product is below 2^106, so the 106-bit wraparound of
    // the running sum never discards real bits.
    always_comb begin
        pp       = r_a * r_b[55 -: DW];
        acc_next = (r_acc << DW) + {{(106-53-DW){1'b0}}, pp};
    end

    // Priority encoder: the highest set bit wins because it is assigned last.
    always_comb begin
        lead = 7'd0;
        for (int i = 0; i < 106; i++) begin
            if (r_acc[i]) lead = 7'(i);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_ena) state_d = MUL;
            MUL:     if (r_cnt == LAST) state_d = NORM;
            NORM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_busy = (state_q != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            o_rdy      <= 1'b0;
            o_result   <= '0;
            o_shift    <= '0;
            o_zero     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_rdy <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_ena) begin
                        r_a   <= i_a;
                        r_b   <= {3'b000, i_b};
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                MUL: begin
                    r_acc <= acc_next;
                    r_b   <= r_b << DW;
                    r_cnt <= r_cnt + 4'd1;
                end
                NORM: begin
                    o_result   <= r_acc;
                    o_shift    <= lead;
                    o_zero     <= (r_acc == '0);
                    o_overflow <= r_acc[105];
                    o_rdy      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul53_seq.sv
// Scoreboard bench for mul53_seq. The driver pushes the expected result and
// the cycle in which o_rdy should arrive. The monitor pops one entry per o_rdy
// and compares it against the DUT outputs.
module tb_mul53_seq;

`ifdef MUL53_RADIX256_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 15;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b0;
    logic [52:0]  a = '0;
    logic [52:0]  b = '0;
    logic         busy, rdy, zero, ovf;
    logic [105:0] result;
    logic [6:0]   shift;

    mul53_seq dut (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_a(a), .i_b(b),
        .o_busy(busy), .o_rdy(rdy), .o_result(result), .o_shift(shift),
        .o_zero(zero), .o_overflow(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [105:0] res;
        logic [6:0]   sh;
        logic         z;
        logic         ov;
        int           at;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] top_bit(input logic [105:0] v);
        for (int i = 105; i >= 0; i--) if (v[i]) return 7'(i);
        return 7'd0;
    endfunction

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rdy) begin
                if (q.size() == 0) begin
                    chk("unexpected_rdy", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("result",   result, e.res);
                    chk("shift",    shift,  e.sh);
                    chk("zero",     zero,   e.z);
                    chk("overflow", ovf,    e.ov);
                    chk("rdy_cycle", cyc,   e.at);
                end
            end
        end
    end

    // Issue one operation. The expected product and shift come from the caller.
    task automatic issue(input logic [52:0] ia, input logic [52:0] ib,
                         input logic [105:0] ep, input logic [6:0] esh,
                         input bit push, input bit hold, output int acc);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("busy_timeout", 1, 0);
        a   = ia;
        b   = ib;
        ena = 1'b1;
        acc = cyc + 1;
        if (push) begin
            e.res = ep; e.sh = esh; e.z = (ep == '0); e.ov = ep[105]; e.at = acc + LAT;
            q.push_back(e);
        end
        @(posedge clk);
        if (!hold) #1 ena = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        repeat (LAT + 4) @(negedge clk);
    endtask

    initial begin
        int acc, prev;
        logic [52:0]  ra, rb;
        logic [105:0] p;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_result", result, 0);
        chk("rst_shift", shift, 0);
        chk("rst_zero", zero, 0);
        chk("rst_ovf", ovf, 0);

        // 1.0 x 1.0
        issue(53'h10000000000000, 53'h10000000000000, 106'd1 << 104, 7'd104, 1, 0, acc);
        @(negedge clk);
        chk("busy_after_accept", busy, 1);
        drain();

        // Maximum operands: 2^106 - 2^54 + 1
        issue(53'h1FFFFFFFFFFFFF, 53'h1FFFFFFFFFFFFF,
              ({106{1'b1}} << 54) | 106'd1, 7'd105, 1, 0, acc);
        drain();

        // Zero operand
        issue(53'h0, 53'h1ABCDEF0123456, 106'd0, 7'd0, 1, 0, acc);
        drain();

        // A second request while busy must be ignored
        issue(53'd3, 53'd5, 106'd15, 7'd3, 1, 0, acc);
        repeat (4) @(posedge clk);
        @(negedge clk);
        a = 53'd7; b = 53'd7; ena = 1'b1;
        @(posedge clk);
        #1 ena = 1'b0;
        drain();

        // Reset mid-operation: no o_rdy, everything returns to zero
        issue(53'h10000000000000, 53'h10000000000000, 106'd0, 7'd0, 0, 0, acc);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        chk("midrst_shift", shift, 0);
        chk("midrst_zero", zero, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_rdy", rdy, 0);
        repeat (LAT + 4) @(negedge clk);
        issue(53'h10000000000001, 53'd2, 106'h20000000000002, 7'd53, 1, 0, acc);
        drain();

        // Streaming with i_ena held high
        prev = 0;
        for (int i = 0; i < 100; i++) begin
            ra = {21'($urandom_range(0, (1 << 21) - 1)), 32'($urandom())};
            rb = {21'($urandom_range(0, (1 << 21) - 1)), 32'($urandom())};
            if (i % 3 == 0) ra[52] = 1'b1;
            if (i % 5 == 0) rb[52] = 1'b1;
            p = {53'd0, ra} * {53'd0, rb};
            issue(ra, rb, p, top_bit(p), 1, 1, acc);
            if (i > 0) chk("stream_interval", acc - prev, LAT + 1);
            prev = acc;
        end
        @(negedge clk);
        ena = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
